lcd_timing_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_cmd_fifo.sv | 67 ++++++
 rtl/lcd_timing_ctrl.sv | 137 +++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, constants and helpers for the HD44780 write-only timing controller.
package lcd_pkg;

    localparam int unsigned CNT_W          = 17;
    localparam int unsigned ENTRY_W        = 9;

    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_T_AS       = 4;
    localparam int unsigned DEF_T_PW       = 12;
    localparam int unsigned DEF_T_H        = 2;
    localparam int unsigned DEF_T_CMD      = 2000;
    localparam int unsigned DEF_T_CLR      = 82000;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    // Return Home ignores bit 0, so 0x02 and 0x03 share this prefix.
    localparam logic [6:0] HOME_MASK = CMD_HOME[7:1];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Swap ASCII letter case on RAM data writes; everything else passes through.
    function automatic logic [7:0] case_swap(input logic en, input logic rs, input logic [7:0] data);
        logic alpha;
        alpha = ((data >= 8'h41) && (data <= 8'h5A)) || ((data >= 8'h61) && (data <= 8'h7A));
        return (en && rs && alpha) ? {data[7:6], ~data[5], data[4:0]} : data;
    endfunction

    // Clear Display and Return Home need the long execution wait.
    function automatic logic is_slow_cmd(input lcd_entry_t e);
        return !e.rs && ((e.data == CMD_CLEAR) || (e.data[7:1] == HOME_MASK));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous show-ahead FIFO of {rs, data} entries with sticky overflow flag.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] head_c_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_F = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_F-1:0]   count_q, count_d;
    logic               full_q, empty_q, ovf_q;
    logic               do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push at full is still accepted.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_F'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_F'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_F'(DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_q | (push_i && full_q && !do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_c_o   = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Queues CPU writes to a 16x2 HD44780 panel and replays them with setup, enable,
// hold and execution-wait timing so software never polls busy.
module lcd_timing_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned T_AS       = DEF_T_AS,
    parameter int unsigned T_PW       = DEF_T_PW,
    parameter int unsigned T_H        = DEF_T_H,
    parameter int unsigned T_CMD      = DEF_T_CMD,
    parameter int unsigned T_CLR      = DEF_T_CLR,
    parameter bit          CASE_SWAP  = 1'b1
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       wr_stb,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA
);

    localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_H   = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] LD_CMD = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(T_CLR - 1);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_zero;
    logic             rs_q, e_q, slow_q;
    logic [7:0]       data_q;
    logic             in_vld_q;
    lcd_entry_t       in_q;
    lcd_entry_t       head;
    logic             fifo_empty;
    logic             pop_c;

    // Decoder strobe is registered once before entering the queue.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            in_vld_q <= 1'b0;
            in_q     <= '0;
        end else begin
            in_vld_q <= wr_stb;
            if (wr_stb) in_q <= '{rs: wr_rs, data: wr_data};
        end
    end

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (nRESET),
        .push_i     (in_vld_q),
        .pop_i      (pop_c),
        .wdata_i    (in_q),
        .head_c_o   (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign pop_c    = (state_q == ST_IDLE) && !fifo_empty;
    assign cnt_zero = (cnt_q == '0);

    // Per-entry sequencer: setup, enable pulse, hold, then execution wait.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            e_q     <= 1'b0;
            slow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        rs_q    <= head.rs;
                        data_q  <= case_swap(CASE_SWAP, head.rs, head.data);
                        slow_q  <= is_slow_cmd(head);
                        cnt_q   <= LD_AS;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        cnt_q   <= LD_PW;
                        e_q     <= 1'b1;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        cnt_q   <= LD_H;
                        e_q     <= 1'b0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        cnt_q   <= slow_q ? LD_CLR : LD_CMD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_E    = e_q;
    assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: per-cycle comparison against a queue/schedule model
// plus table vectors and hand-written timing sequences.
module tb_lcd_timing_ctrl;

    localparam int DEPTH = 16;
    localparam int T_AS  = 4;
    localparam int T_PW  = 12;
    localparam int T_H   = 2;
    localparam int T_CMD = 20;
    localparam int T_CLR = 60;
    localparam int NORM  = T_AS + T_PW + T_H + T_CMD + 1;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       wr_stb, wr_rs;
    logic [7:0] wr_data;
    logic       fifo_full, overflow, busy;
    logic       LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_DATA;

    always #5 CLK = ~CLK;

    lcd_timing_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .T_AS       (T_AS),
        .T_PW       (T_PW),
        .T_H        (T_H),
        .T_CMD      (T_CMD),
        .T_CLR      (T_CLR),
        .CASE_SWAP  (1'b1)
    ) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .wr_stb    (wr_stb),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_E     (LCD_E),
        .LCD_DATA  (LCD_DATA)
    );

    int checks = 0;
    int errors = 0;

    // Model: accepted entries in a queue, pops scheduled from each entry's duration.
    int         m_e, m_next_pop, m_p, m_dur;
    logic [8:0] mq[$];
    logic       m_in_v;
    logic [8:0] m_in;
    logic       m_ovf, m_rs;
    logic [7:0] m_data;

    logic [8:0] seen[$];
    logic       prev_e;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic       exp_rs;
        logic [7:0] exp_d;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [7:0] ref_swap(input logic rs, input logic [7:0] d);
        if (rs && (((d >= 8'h41) && (d <= 8'h5A)) || ((d >= 8'h61) && (d <= 8'h7A))))
            return d ^ 8'h20;
        return d;
    endfunction

    function automatic int ref_dur(input logic [8:0] ent);
        int w;
        w = (!ent[8] && (ent[7:0] >= 8'h01) && (ent[7:0] <= 8'h03)) ? T_CLR : T_CMD;
        return T_AS + T_PW + T_H + w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_next_pop = 0; m_p = -100000; m_dur = 0;
        mq.delete();
        m_in_v = 1'b0; m_in = '0; m_ovf = 1'b0; m_rs = 1'b0; m_data = '0;
    endtask

    task automatic model_step();
        int         pre;
        logic       pop;
        logic [8:0] ent;
        m_e++;
        pre = mq.size();
        pop = (m_e >= m_next_pop) && (pre > 0);
        if (pop) begin
            ent        = mq.pop_front();
            m_p        = m_e;
            m_dur      = ref_dur(ent);
            m_next_pop = m_e + m_dur + 1;
            m_rs       = ent[8];
            m_data     = ref_swap(ent[8], ent[7:0]);
        end
        if (m_in_v) begin
            if ((pre < DEPTH) || pop) mq.push_back(m_in);
            else m_ovf = 1'b1;
        end
        m_in_v = wr_stb;
        m_in   = {wr_rs, wr_data};
    endtask

    task automatic tick();
        logic exp_e, exp_busy;
        @(posedge CLK);
        if (!nRESET) model_reset();
        else model_step();
        @(negedge CLK);
        if (nRESET) begin
            exp_e    = (m_p >= 0) && ((m_e - m_p) >= T_AS) && ((m_e - m_p) < T_AS + T_PW);
            exp_busy = ((m_p >= 0) && (m_e < m_p + m_dur)) || (mq.size() > 0);
            chk("cycle", {LCD_E, LCD_RS, LCD_DATA, LCD_RW, busy, fifo_full, overflow},
                         {exp_e, m_rs, m_data, 1'b0, exp_busy, (mq.size() == DEPTH), m_ovf});
            if (LCD_E && !prev_e) seen.push_back({LCD_RS, LCD_DATA});
            prev_e = LCD_E;
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        wr_stb = 1'b1; wr_rs = rs; wr_data = d;
        tick();
        wr_stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick(); tick();
        while (busy && n < budget) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_rise(input int budget);
        int n = 0;
        while (!LCD_E && n < budget) begin tick(); n++; end
        chk("e_rise_timeout", LCD_E, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{1'b1, 8'h61, 1'b1, 8'h41};
        tbl[1]  = '{1'b1, 8'h41, 1'b1, 8'h61};
        tbl[2]  = '{1'b1, 8'h5A, 1'b1, 8'h7A};
        tbl[3]  = '{1'b1, 8'h7A, 1'b1, 8'h5A};
        tbl[4]  = '{1'b1, 8'h40, 1'b1, 8'h40};
        tbl[5]  = '{1'b1, 8'h5B, 1'b1, 8'h5B};
        tbl[6]  = '{1'b1, 8'h60, 1'b1, 8'h60};
        tbl[7]  = '{1'b1, 8'h7B, 1'b1, 8'h7B};
        tbl[8]  = '{1'b0, 8'h61, 1'b0, 8'h61};
        tbl[9]  = '{1'b1, 8'h30, 1'b1, 8'h30};
        tbl[10] = '{1'b0, 8'h01, 1'b0, 8'h01};

        nRESET = 1'b0; wr_stb = 1'b0; wr_rs = 1'b0; wr_data = '0; prev_e = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset_outs", {LCD_E, LCD_RS, LCD_DATA, LCD_RW, busy, fifo_full, overflow}, 0);
        nRESET = 1'b1;

        // Table: one write each, checked on the presented byte.
        for (int i = 0; i < 11; i++) begin
            seen.delete();
            wr(tbl[i].rs, tbl[i].d);
            wait_idle(200);
            chk("tbl_count", seen.size(), 1);
            if (seen.size() > 0) chk("tbl_entry", seen[0], {tbl[i].exp_rs, tbl[i].exp_d});
        end

        // Single write timing.
        wr(1'b1, 8'h61);
        n = 0; while (LCD_DATA != 8'h41 && n < 10) begin tick(); n++; end
        chk("data_latency", n, 2);
        n = 0; while (!LCD_E && n < 20) begin tick(); n++; end
        chk("setup_cycles", n, T_AS);
        n = 0; while (LCD_E && n < 40) begin tick(); n++; end
        chk("pulse_cycles", n, T_PW);
        n = 0; while (busy && n < 100) begin tick(); n++; end
        chk("tail_cycles", n, T_H + T_CMD);

        // Clear command followed by data: long wait before the next pulse.
        wr(1'b0, 8'h01);
        wr(1'b1, 8'h30);
        wait_rise(20);
        n = 0; while (LCD_E && n < 40) begin tick(); n++; end
        chk("clr_pulse", n, T_PW);
        n = 0; while (!LCD_E && n < 200) begin tick(); n++; end
        chk("clr_gap", n, T_H + T_CLR + 1 + T_AS);
        chk("after_clr", {LCD_RS, LCD_DATA}, {1'b1, 8'h30});
        wait_idle(200);

        // Overflow: 17 strobes while the first entry executes.
        wr(1'b1, 8'h41);
        wait_rise(20);
        for (int i = 0; i < 17; i++) begin
            wr_stb = 1'b1; wr_rs = 1'b1; wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_stb = 1'b0;
        chk("ovf_full_pre", {fifo_full, overflow}, 2'b10);
        tick();
        chk("ovf_set", {fifo_full, overflow}, 2'b11);
        seen.delete();
        wait_idle(DEPTH * NORM + 100);
        chk("ovf_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            chk("ovf_order", seen[i], {1'b1, ref_swap(1'b1, 8'(8'h50 + i))});

        // Wrap-around: 40 paced writes.
        seen.delete();
        for (int i = 0; i < 40; i++) begin
            wr(1'b1, 8'(8'h20 + i));
            repeat (44) tick();
        end
        wait_idle(200);
        chk("wrap_count", seen.size(), 40);
        for (int i = 0; i < 40 && i < seen.size(); i++)
            chk("wrap_order", seen[i], {1'b1, ref_swap(1'b1, 8'(8'h20 + i))});

        // Reset during the enable pulse.
        wr(1'b1, 8'h70); wr(1'b1, 8'h71); wr(1'b1, 8'h72);
        wait_rise(20);
        tick();
        #2 nRESET = 1'b0;
        model_reset();
        #1 chk("reset_mid_pulse", {LCD_E, LCD_RS, LCD_DATA, busy, fifo_full, overflow}, 0);
        tick(); tick();
        nRESET = 1'b1; prev_e = 1'b0;
        seen.delete();
        wr(1'b1, 8'h62);
        wait_idle(200);
        chk("post_reset_count", seen.size(), 1);
        if (seen.size() > 0) chk("post_reset_entry", seen[0], {1'b1, 8'h42});

        // Push coincident with the IDLE pop while full.
        wr(1'b1, 8'h31);
        wait_rise(20);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h21 + i));
        tick();
        chk("pp_full", fifo_full, 1);
        seen.delete();
        n = 0; while (m_next_pop != m_e + 2 && n < 100) begin tick(); n++; end
        chk("pp_align", (n < 100), 1);
        wr(1'b1, 8'h2A);
        tick();
        chk("pp_after", {fifo_full, overflow}, 2'b10);
        wait_idle(17 * NORM + 100);
        chk("pp_count", seen.size(), 17);
        if (seen.size() == 17) chk("pp_last", seen[16], {1'b1, 8'h2A});

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                for (int j = 0; j < 18; j++) wr(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else begin
                wr_stb  = ($urandom_range(0, 39) == 0);
                wr_rs   = 1'($urandom_range(0, 1));
                wr_data = 8'($urandom_range(0, 255));
                tick();
            end
        end
        wr_stb = 1'b0;
        wait_idle(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
